easyaxi_slv_rd_ctrl: RTL

Slave-side read controller that sits directly downstream of the AR channel between `EASYAXI_MST` and `EASYAXI_SLV`. It accepts AR requests, queues up to `OST_DEPTH` outstanding reads, and returns one single-beat R response per request in acceptance order after a fixed access latency. It provides the R channel that the current AR-only path lacks, so a full read round-trip can run end to end.

---
 rtl/easyaxi_slv_rd_ctrl_pkg.sv | 32 +++
 rtl/easyaxi_slv_rd_ctrl_if.sv | 32 +++
 rtl/easyaxi_sync_fifo.sv | 50 +++++
 rtl/easyaxi_slv_rd_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/easyaxi_slv_rd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | easyaxi_slv_rd_ctrl_pkg : AXI widths, response codes and shared types |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package easyaxi_slv_rd_ctrl_pkg;

   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } head_state_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
   } ar_entry_t;

   // Zero-extends or truncates an address onto the read data bus.
   function automatic logic [AXI_DATA_WIDTH-1:0] addr_to_data(input logic [AXI_ADDR_WIDTH-1:0] addr);
      return AXI_DATA_WIDTH'(addr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/easyaxi_slv_rd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | easyaxi_slv_rd_ctrl_if : AR and R channel bundle with modports        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface easyaxi_slv_rd_ctrl_if;
   import easyaxi_slv_rd_ctrl_pkg::*;

   logic                      axi_slv_arvalid;
   logic                      axi_slv_arready;
   logic [AXI_ID_WIDTH-1:0]   axi_slv_arid;
   logic [AXI_ADDR_WIDTH-1:0] axi_slv_araddr;
   logic                      axi_slv_rvalid;
   logic                      axi_slv_rready;
   logic [AXI_ID_WIDTH-1:0]   axi_slv_rid;
   logic [AXI_DATA_WIDTH-1:0] axi_slv_rdata;
   logic [1:0]                axi_slv_rresp;
   logic                      axi_slv_rlast;

   modport slave (
      input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_rready,
      output axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
             axi_slv_rresp, axi_slv_rlast
   );

   modport master (
      output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_rready,
      input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
             axi_slv_rresp, axi_slv_rlast
   );
endinterface
`default_nettype wire

// File: rtl/easyaxi_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | easyaxi_sync_fifo : synchronous FIFO with full/empty flags and count  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module easyaxi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   input  wire logic                     push,
   input  wire logic [WIDTH-1:0]         push_data,
   input  wire logic                     pop,
   output logic      [WIDTH-1:0]         pop_data,
   output logic                          full,
   output logic                          empty,
   output logic      [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra MSB distinguishes full from empty when the index bits match.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign count    = wr_ptr - rd_ptr;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule
`default_nettype wire

// File: rtl/easyaxi_slv_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | easyaxi_slv_rd_ctrl : queued AR requests answered in order on R after |
// | a fixed latency; EASYAXI_SLV_DECERR_EN enables DECERR above ADDR_LIMIT|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module easyaxi_slv_rd_ctrl
   import easyaxi_slv_rd_ctrl_pkg::*;
#(
   parameter int                        OST_DEPTH  = 4,
   parameter int                        RD_LATENCY = 2,
   parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = 'h1000
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             enable,
   easyaxi_slv_rd_ctrl_if.slave  bus
);
   localparam int AW    = $clog2(OST_DEPTH);
   localparam int CNT_W = $clog2(RD_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   head_state_t               state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic                      run;
   logic                      arready, rvalid, push, pop, start, head_next;
   logic                      fifo_full, fifo_empty;
   logic [AW:0]               count, count_nxt;
   ar_entry_t                 push_entry, head;
   logic [1:0]                resp_code;
   logic [AXI_DATA_WIDTH-1:0] resp_data;

   assign push_entry = {bus.axi_slv_arid, bus.axi_slv_araddr};
   assign arready    = enable && run && !fifo_full;
   assign push       = bus.axi_slv_arvalid && arready;
   assign pop        = rvalid && bus.axi_slv_rready;
   assign count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign head_next  = (count_nxt != '0);

   easyaxi_sync_fifo #(
      .WIDTH ($bits(ar_entry_t)),
      .DEPTH (OST_DEPTH)
   ) u_ar_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   // Holds arready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         run <= 1'b0;
      else
         run <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start     = 1'b0;
      case (state)
         ST_IDLE: start = head_next;
         ST_WAIT: begin
            if (cnt <= CNT_ONE) begin
               state_nxt = ST_RESP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         ST_RESP: begin
            if (pop) begin
               state_nxt = ST_IDLE;
               start     = head_next;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // A new head starts its latency on the edge it becomes eligible.
      if (start) begin
         if (RD_LATENCY == 1) begin
            state_nxt = ST_RESP;
         end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_LOAD;
         end
      end
   end

   always_comb begin
      rvalid    = (state == ST_RESP) && !fifo_empty;
      resp_code = AXI_RESP_OKAY;
      resp_data = addr_to_data(head.addr);
`ifdef EASYAXI_SLV_DECERR_EN
      if (head.addr >= ADDR_LIMIT) begin
         resp_code = AXI_RESP_DECERR;
         resp_data = '0;
      end
`endif
   end

`ifndef EASYAXI_SLV_DECERR_EN
   logic unused_addr_limit;
   assign unused_addr_limit = ^ADDR_LIMIT;
`endif

   assign bus.axi_slv_arready = arready;
   assign bus.axi_slv_rvalid  = rvalid;
   assign bus.axi_slv_rlast   = rvalid;
   assign bus.axi_slv_rid     = rvalid ? head.id : '0;
   assign bus.axi_slv_rdata   = rvalid ? resp_data : '0;
   assign bus.axi_slv_rresp   = rvalid ? resp_code : 2'b00;
endmodule
`default_nettype wire
